// File: rtl/pcileech_cfgtlp_responder.sv
// Config-TLP responder: decodes CfgRd0/CfgWr0 from the RX stream, drives shadow
// config-space strobes and returns CplD/Cpl on the TX stream. One request in flight.
module pcileech_cfgtlp_responder #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] tlps_rx_tdata,
  input  logic [7:0]  tlps_rx_tkeep,
  input  logic        tlps_rx_tvalid,
  input  logic        tlps_rx_tlast,
  output logic        tlps_rx_tready,
  output logic [63:0] tlps_tx_tdata,
  output logic [7:0]  tlps_tx_tkeep,
  output logic        tlps_tx_tvalid,
  output logic        tlps_tx_tlast,
  input  logic        tlps_tx_tready,
  input  logic [15:0] pcie_id,
  output logic        sh_rx_rden,
  output logic        sh_rx_wren,
  output logic [9:0]  sh_rx_addr,
  output logic [3:0]  sh_rx_be,
  output logic [31:0] sh_rx_data,
  output logic [7:0]  sh_rx_tag,
  input  logic        sh_tx_valid,
  input  logic        sh_tx_tlprd,
  input  logic [7:0]  sh_tx_tag,
  input  logic [31:0] sh_tx_data,
  output logic [15:0] stat_timeout_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR2, S_WAITRD, S_TX0, S_TX1, S_DROP
  } state_t;

  localparam logic [31:0] DW0_CFGRD0 = 32'h0400_0001;
  localparam logic [31:0] DW0_CFGWR0 = 32'h4400_0001;
  localparam logic [31:0] DW0_CPLD   = 32'h4A00_0001;
  localparam logic [31:0] DW0_CPL    = 32'h0A00_0000;
  localparam logic [2:0]  ST_SC      = 3'b000;
  localparam logic [2:0]  ST_UR      = 3'b001;
  localparam int          TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_nxt;
  logic          rx_fire;
  logic          hdr_ok;
  logic          hdr_commit;
  logic          rd_match;
  logic          rd_timeout;
  logic          is_wr;
  logic          cpl_has_data;
  logic [2:0]    cpl_status;
  logic [TW-1:0] timer;
  logic [15:0]   hdr_req_id;
  logic [7:0]    hdr_tag;
  logic [3:0]    hdr_be;
  logic [15:0]   req_id;
  logic [31:0]   cpl_data;

  // TLP payload DWs are big-endian on the wire; the shadow BRAM is little-endian.
  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // RX is only accepted while decoding headers or draining a dropped TLP.
  assign tlps_rx_tready = !rst && (state == S_IDLE || state == S_HDR2 || state == S_DROP);
  assign rx_fire    = tlps_rx_tvalid && tlps_rx_tready;
  assign hdr_ok     = (tlps_rx_tkeep == 8'hFF) &&
                      (tlps_rx_tdata[31:0] == DW0_CFGRD0 || tlps_rx_tdata[31:0] == DW0_CFGWR0);
  assign hdr_commit = (state == S_HDR2) && rx_fire && tlps_rx_tlast;
  assign rd_match   = sh_tx_valid && sh_tx_tlprd && (sh_tx_tag == sh_rx_tag);
  assign rd_timeout = (timer == TIMER_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and TX beat formatting; TX fields come only from held context,
  // so they stay stable while the downstream stalls.
  always_comb begin
    state_nxt      = state;
    tlps_tx_tvalid = 1'b0;
    tlps_tx_tdata  = '0;
    tlps_tx_tkeep  = '0;
    tlps_tx_tlast  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (rx_fire && !tlps_rx_tlast) state_nxt = hdr_ok ? S_HDR2 : S_DROP;
      end
      S_HDR2: begin
        if (rx_fire) begin
          if (!tlps_rx_tlast) state_nxt = S_DROP;
          else if (is_wr)     state_nxt = S_TX0;
          else                state_nxt = S_WAITRD;
        end
      end
      S_WAITRD: begin
        if (rd_match || rd_timeout) state_nxt = S_TX0;
      end
      S_TX0: begin
        tlps_tx_tvalid = 1'b1;
        tlps_tx_tdata  = {pcie_id, cpl_status, 1'b0, 12'd4,
                          (cpl_has_data ? DW0_CPLD : DW0_CPL)};
        tlps_tx_tkeep  = 8'hFF;
        if (tlps_tx_tready) state_nxt = S_TX1;
      end
      S_TX1: begin
        tlps_tx_tvalid = 1'b1;
        tlps_tx_tdata  = {(cpl_has_data ? cpl_data : 32'h0), req_id, sh_rx_tag, 8'h00};
        tlps_tx_tkeep  = cpl_has_data ? 8'hFF : 8'h0F;
        tlps_tx_tlast  = 1'b1;
        if (tlps_tx_tready) state_nxt = S_IDLE;
      end
      S_DROP: begin
        if (rx_fire && tlps_rx_tlast) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control: strobes, shadow-side outputs, completion kind, timeout timer and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_rx_rden       <= 1'b0;
      sh_rx_wren       <= 1'b0;
      sh_rx_addr       <= '0;
      sh_rx_be         <= '0;
      sh_rx_data       <= '0;
      sh_rx_tag        <= '0;
      stat_timeout_cnt <= '0;
      timer            <= '0;
      is_wr            <= 1'b0;
      cpl_has_data     <= 1'b0;
      cpl_status       <= ST_SC;
    end else begin
      sh_rx_rden <= 1'b0;
      sh_rx_wren <= 1'b0;
      if (state == S_IDLE && rx_fire) is_wr <= (tlps_rx_tdata[31:0] == DW0_CFGWR0);
      if (hdr_commit) begin
        sh_rx_addr   <= tlps_rx_tdata[11:2];
        sh_rx_be     <= hdr_be;
        sh_rx_tag    <= hdr_tag;
        timer        <= '0;
        cpl_status   <= ST_SC;
        cpl_has_data <= !is_wr;
        if (is_wr) begin
          sh_rx_wren <= 1'b1;
          sh_rx_data <= bswap32(tlps_rx_tdata[63:32]);
        end else begin
          sh_rx_rden <= 1'b1;
        end
      end
      if (state == S_WAITRD && !rd_match) begin
        if (rd_timeout) begin
          cpl_has_data <= 1'b0;
          cpl_status   <= ST_UR;
          if (stat_timeout_cnt != 16'hFFFF) stat_timeout_cnt <= stat_timeout_cnt + 16'd1;
        end else begin
          timer <= timer + TW'(1);
        end
      end
    end
  end

  // Datapath context: header fields and read data, no reset needed.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && rx_fire) begin
      hdr_req_id <= tlps_rx_tdata[63:48];
      hdr_tag    <= tlps_rx_tdata[47:40];
      hdr_be     <= tlps_rx_tdata[35:32];
    end
    if (hdr_commit) req_id <= hdr_req_id;
    if (state == S_WAITRD && rd_match) cpl_data <= bswap32(sh_tx_data);
  end

endmodule
